pipe_stage_reg: RTL

//   Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) with valid/ready flow control.

---
 rtl/pipe_stage_reg_pkg.sv | 13 +
 rtl/pipe_stage_reg_skid_buf.sv | 36 +++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: occupancy states and flush encodings.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'd0,
    PIPE_ST_ONE   = 2'd1,
    PIPE_ST_TWO   = 2'd2
  } pipe_st_e;

  localparam logic FLUSH_ON  = 1'b1;
  localparam logic FLUSH_OFF = 1'b0;

endpackage

// File: rtl/pipe_stage_reg_skid_buf.sv
// Second-entry skid register for pipe_stage_reg; used only when PIPE_STAGE_SKID_EN is defined.
module pipe_stage_reg_skid_buf #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

  // Payload only needs to be correct while valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      ctrl <= in_ctrl;
      data <= in_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control and saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add a 2-entry skid buffer so in_ready no longer depends on out_ready.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W   = 32,
  parameter int                 CTRL_W   = 16,
  parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic flush_act;
  logic accept;
  logic load_in;
  logic load_skid;
  logic drop;

  assign flush_act = (flush == FLUSH_ON);
  assign accept    = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  pipe_st_e          st;

  // Occupancy is fully described by the two valid flops.
  always_comb begin
    st = PIPE_ST_EMPTY;
    if (skid_valid)     st = PIPE_ST_TWO;
    else if (out_valid) st = PIPE_ST_ONE;
  end

  assign in_ready = !flush_act && !skid_valid;

  always_comb begin
    load_in   = 1'b0;
    load_skid = 1'b0;
    drop      = 1'b0;
    case (st)
      PIPE_ST_EMPTY: load_in = accept;
      PIPE_ST_ONE: begin
        load_in = accept && out_ready;
        drop    = !accept && out_ready;
      end
      PIPE_ST_TWO:   load_skid = out_ready;
      default: ;
    endcase
  end

  pipe_stage_reg_skid_buf #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush_act),
    .load    (accept && (st == PIPE_ST_ONE) && !out_ready),
    .unload  (load_skid && !flush_act),
    .in_ctrl (in_ctrl),
    .in_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );
`else
  assign in_ready = !flush_act && (!out_valid || out_ready);

  always_comb begin
    load_in   = accept;
    load_skid = 1'b0;
    drop      = out_valid && out_ready && !accept;
  end
`endif

  // Output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_NOP;
      out_data  <= '0;
    end else if (flush_act) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_NOP;
    end else if (load_in) begin
      out_valid <= 1'b1;
      out_ctrl  <= in_ctrl;
      out_data  <= in_data;
    end else if (load_skid) begin
`ifdef PIPE_STAGE_SKID_EN
      out_valid <= 1'b1;
      out_ctrl  <= skid_ctrl;
      out_data  <= skid_data;
`endif
    end else if (drop) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule
